// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared register offsets, FSM state type and defaults for irq_ctrl
package irq_pkg;

    localparam int ID_W_DEF = 3;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_MODE    = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-wins priority encoder
module irq_prio_enc #(
    parameter int NSRC = 6,
    parameter int ID_W = 3
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - programmable interrupt controller with req/ack/EOI handshake to the CPU
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC = 6,
    parameter int ID_W = ID_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    input  logic [NSRC-1:0] irq_in,
    input  logic            ack,
    output logic            irq_out,
    output logic [ID_W-1:0] cur_id
);

    logic [NSRC-1:0] enable_r;
    logic [NSRC-1:0] mode_r;
    logic [NSRC-1:0] pend_r;
    logic [NSRC-1:0] prev_r;
    irq_state_t      state;

    logic            pend_valid;
    logic [ID_W-1:0] sel_id;
    logic            claim;
    logic            eoi;
    logic [NSRC-1:0] claim_mask;
    logic [NSRC-1:0] w1c_mask;
    logic [NSRC-1:0] edge_next;
    logic [NSRC-1:0] pend_next;
    logic            unused_din;

    assign unused_din = ^din[31:NSRC];

    irq_prio_enc #(
        .NSRC (NSRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req   (pend_r & enable_r),
        .valid (pend_valid),
        .id    (sel_id)
    );

    assign claim = (state == ST_ASSERT) && ack && pend_valid;
    assign eoi   = (state == ST_SERVICE) && we && (addr == REG_STATUS);

    // A fresh rising edge outranks any clear landing on the same bit.
    always_comb begin
        w1c_mask = (we && addr == REG_PENDING) ? din[NSRC-1:0] : '0;
        for (int i = 0; i < NSRC; i++) begin
            claim_mask[i] = claim && (sel_id == ID_W'(i));
        end
        edge_next = (irq_in & ~prev_r) | (pend_r & ~(w1c_mask | claim_mask));
        pend_next = (mode_r & edge_next) | (~mode_r & irq_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_r <= '0;
            mode_r   <= '0;
            pend_r   <= '0;
            prev_r   <= '0;
        end else begin
            pend_r <= pend_next;
            prev_r <= irq_in;
            if (we && addr == REG_ENABLE) begin
                enable_r <= din[NSRC-1:0];
            end
            if (we && addr == REG_MODE) begin
                mode_r <= din[NSRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            irq_out <= 1'b0;
            cur_id  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        state   <= ST_ASSERT;
                        irq_out <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (ack) begin
                        state   <= ST_SERVICE;
                        cur_id  <= sel_id;
                        irq_out <= 1'b0;
                    end else if (!pend_valid) begin
                        state   <= ST_IDLE;
                        irq_out <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    irq_out <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            REG_ENABLE:  dout[NSRC-1:0] = enable_r;
            REG_MODE:    dout[NSRC-1:0] = mode_r;
            REG_PENDING: dout[NSRC-1:0] = pend_r;
            default: begin
                dout[9:8]      = state;
                dout[4]        = pend_valid;
                dout[ID_W-1:0] = sel_id;
            end
        endcase
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Programmable interrupt controller between the peripheral interrupt lines (timers, external interrupt) and the CPU's hardware-interrupt input. It latches up to six sources, applies per-source enable and edge/level mode, selects the highest-priority request, and runs a request/acknowledge/end-of-interrupt handshake with the CPU. Software configures it through a bridge-decoded, word-addressed register window. Timer IRQs and `interrupt` connect to `irq_in`; `irq_out` drives the CPU interrupt request.

## Interface
- `NSRC`, 6: number of interrupt sources, 1..8.
- `ID_W`, 3: width of source id, ≥ clog2(NSRC).

- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `addr` in 2: register word select (byte address bits [3:2]).
- `we` in 1: register write strobe, one cycle per write.
- `din` in 32: write data.
- `dout` out 32: combinational read data for `addr`; unused bits 0.
- `irq_in` in NSRC: raw source lines, synchronous to `clk`.
- `ack` in 1: CPU took the interrupt, one-cycle pulse.
- `irq_out` out 1: interrupt request to CPU, registered.
- `cur_id` out ID_W: id of source in service, registered.

## Operation
- Registers: 0 ENABLE (rw, bits [NSRC-1:0]); 1 MODE (rw, 1=edge, 0=level); 2 PENDING (read; write-1-to-clear edge bits, ignored for level bits); 3 STATUS (read {state[1:0] at [9:8], pend_valid at [4], sel_id at [ID_W-1:0]}; any write = EOI).
- Level source: pending bit = `irq_in` sampled each edge.
- Edge source: pending set on sampled 0→1 of `irq_in` (previous-sample register); cleared by W1C or by `ack` claiming it.
- Selection: sel_id = lowest index with pending & ENABLE; pend_valid = any such bit.
- FSM states IDLE, ASSERT, SERVICE:
  - IDLE: pend_valid → ASSERT, `irq_out`←1.
  - ASSERT: `ack` → SERVICE, `cur_id`←sel_id, clear that pending bit if edge, `irq_out`←0. Else if !pend_valid (disabled/cleared) → IDLE, `irq_out`←0.
  - SERVICE: write to reg 3 (EOI) → IDLE. No nesting; new requests stay pending.
- `ack` outside ASSERT is ignored. EOI outside SERVICE is ignored.
- Simultaneous: edge set and W1C/claim clear on same bit → set wins. ENABLE/MODE write same cycle as sampling takes effect next cycle.

## Timing
- Reset values: ENABLE=0, MODE=0, PENDING=0, prev-sample=0, state IDLE, `irq_out`=0, `cur_id`=0, `dout` reflects reset registers.
- `irq_in` rise before edge N → PENDING set after N → `irq_out`=1 after N+1 (2-cycle latency).
- `ack` at edge M → `irq_out`=0 and `cur_id` valid after M.
- EOI at edge K → IDLE after K; if still pending, `irq_out`=1 after K+1.
- `dout` is same-cycle combinational; reads have no side effects.
- `reset` mid-handshake returns to IDLE immediately, no EOI required.

## Structure
- Shared package `irq_pkg`: register offsets (ENABLE, MODE, PENDING, STATUS), FSM state enum, ID_W default.
- Sub-module `irq_prio_enc`: combinational NSRC-bit lowest-index priority encoder → {valid, id}.

## Test plan
- Reset: hold `reset`, drive `irq_in`=6'h3F → `irq_out`=0, all reads 0; release, ENABLE=0 → `irq_out` stays 0.
- Edge priority: ENABLE=6'h3F, MODE=6'h3F; raise bits 4 and 1 same cycle → `irq_out`=1 two cycles later, STATUS id=1; `ack` → `cur_id`=1, PENDING=6'h10; EOI → `irq_out`=1 one cycle after IDLE, id=4.
- Level: MODE=0, ENABLE=6'h04, hold `irq_in[2]`=1 → request, ack, EOI → re-requests; drop `irq_in[2]` before ack → `irq_out` falls, state IDLE.
- W1C race: edge on bit 0 in same cycle as W1C of bit 0 → PENDING[0]=1.
- Withdrawal: in ASSERT, write ENABLE=0 → `irq_out`=0 next cycle; stray `ack`/EOI in IDLE change nothing.
- Async reset in SERVICE → immediate IDLE, `irq_out`=0, `cur_id`=0.
